// File: rtl/calc_mac_method_if.sv
// ============================================================================
//  Module      : calc_mac_method_if
//  Description : Method-call bus for calc_mac_method. The caller drives the
//                three arguments and a level request, and receives the busy
//                flag and the 32-bit return value.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface calc_mac_method_if;
  logic [31:0] calc_c1;
  logic [31:0] calc_c2;
  logic [31:0] calc_c3;
  logic        calc_req;
  logic        calc_busy;
  logic [31:0] calc_return;

  // Caller side
  modport master (
    output calc_c1,
    output calc_c2,
    output calc_c3,
    output calc_req,
    input  calc_busy,
    input  calc_return
  );

  // Callee side (the MAC engine)
  modport slave (
    input  calc_c1,
    input  calc_c2,
    input  calc_c3,
    input  calc_req,
    output calc_busy,
    output calc_return
  );
endinterface

`default_nettype wire

// File: rtl/calc_mac_method.sv
// ============================================================================
//  Module      : calc_mac_method
//  Description : Sequential multiply-accumulate method:
//                  calc_return = (calc_c1 * calc_c2 + calc_c3) mod 2^32
//                computed with a shift-and-add multiplier (one multiplier bit
//                per cycle) followed by a single add cycle. A call starts on
//                a rising edge of calc_req while idle.
//  Options     : CALC_EARLY_TERM_EN - leave the multiply loop as soon as the
//                remaining multiplier bits are all zero (result unchanged,
//                latency becomes data dependent).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module calc_mac_method (
  input  wire               clk,
  input  wire               reset,    // asynchronous, active low
  calc_mac_method_if.slave  calc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        req_prev;
  logic        start;
  logic        mul_last;
  logic        busy_q;
  logic [31:0] return_q;

  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] addend;
  logic [4:0]  count;

  // A call only begins on a fresh 0->1 request edge seen while idle, so a
  // request held high, or toggled during a call, never queues a second call.
  assign start = calc.calc_req & ~req_prev & (state == IDLE);

  // Decide whether the current MUL cycle is the last one.
`ifdef CALC_EARLY_TERM_EN
  logic [31:0] mplier_shifted;
  assign mplier_shifted = mplier >> 1;
  // Stop once no multiplier bits remain after this cycle's shift; the
  // 32-cycle cap still applies (only reachable when bit 31 of c2 is set).
  assign mul_last = (count == 5'd31) || (mplier_shifted == 32'd0);
`else
  assign mul_last = (count == 5'd31);
`endif

  // Next-state logic for the IDLE -> MUL -> ADD -> IDLE sequence.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)    state_next = MUL;
      MUL:     if (mul_last) state_next = ADD;
      ADD:                   state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // State register; busy is registered alongside so it tracks the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
    end
  end

  // Request edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_prev <= 1'b0;
    end else begin
      req_prev <= calc.calc_req;
    end
  end

  // Shift-and-add datapath: arguments are captured at start so later input
  // changes cannot disturb a running call.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      addend <= 32'd0;
      count  <= 5'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= calc.calc_c1;
            mplier <= calc.calc_c2;
            addend <= calc.calc_c3;
            acc    <= 32'd0;
            count  <= 5'd0;
          end
        end
        MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Return register: only the ADD cycle updates it, so the previous result
  // stays visible for the whole of the next call and a reset mid-call shows
  // no partial product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      return_q <= 32'd0;
    end else if (state == ADD) begin
      return_q <= acc + addend;
    end
  end

  assign calc.calc_busy   = busy_q;
  assign calc.calc_return = return_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_mac_method.sv
// ============================================================================
//  Module      : tb_calc_mac_method
//  Description : Self-checking bench for calc_mac_method. Expected results
//                are the plain arithmetic c1*c2+c3 truncated to 32 bits;
//                expected latency follows the build option.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_calc_mac_method;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_ret;   // value calc_return must show between ADD edges

  calc_mac_method_if calc_bus ();

  calc_mac_method dut (
    .clk   (clk),
    .reset (reset),
    .calc  (calc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result.
  function automatic logic [31:0] model_result(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic [31:0] c);
    logic [63:0] full;
    full = {32'd0, a} * {32'd0, b} + {32'd0, c};
    return full[31:0];
  endfunction

  // Reference busy duration in cycles.
  function automatic int model_len(input logic [31:0] b);
    int msb;
`ifdef CALC_EARLY_TERM_EN
    if (b == 32'd0) return 2;
    msb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return msb + 2;
`else
    msb = 0;
    if (b == 32'd0) msb = 0;
    return 33;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called on the negedge just after the request edge was driven. Waits for
  // busy, counts busy cycles while checking the old result is held, then
  // checks duration and new result. Optionally scrambles the args mid-call.
  task automatic wait_call(input string tag, input logic [31:0] exp_res,
                           input int exp_len, input bit scramble);
    int guard;
    int n;
    int hold_bad;
    guard = 0;
    @(negedge clk);
    while (calc_bus.calc_busy !== 1'b1 && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_busy_rise"}, {31'd0, calc_bus.calc_busy}, 32'd1);
    n = 0;
    hold_bad = 0;
    while (calc_bus.calc_busy === 1'b1 && n < 100) begin
      if (calc_bus.calc_return !== exp_ret) hold_bad++;
      if (scramble && n == 5) begin
        calc_bus.calc_c1 = $urandom;
        calc_bus.calc_c2 = $urandom;
        calc_bus.calc_c3 = $urandom;
      end
      n++;
      @(negedge clk);
    end
    chk({tag, "_hold"}, hold_bad, 32'd0);
    chk({tag, "_len"}, n, exp_len);
    chk({tag, "_result"}, calc_bus.calc_return, exp_res);
    exp_ret = exp_res;
  endtask

  // Request low for exactly one cycle, then high, starting at a negedge.
  task automatic run_call(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c);
    calc_bus.calc_req = 1'b0;
    calc_bus.calc_c1  = a;
    calc_bus.calc_c2  = b;
    calc_bus.calc_c3  = c;
    @(negedge clk);
    calc_bus.calc_req = 1'b1;
    wait_call(tag, model_result(a, b, c), model_len(b), 1'b0);
  endtask

  // Linear directed sequence.
  initial begin
    logic [31:0] a, b, c, r;
    int busy_seen;
    checks = 0;
    errors = 0;
    exp_ret = 32'd0;
    reset = 1'b1;
    calc_bus.calc_req = 1'b0;
    calc_bus.calc_c1 = 32'd0;
    calc_bus.calc_c2 = 32'd0;
    calc_bus.calc_c3 = 32'd0;

    // Reset low for cycles 3..8
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, calc_bus.calc_busy}, 32'd0);
    chk("rst_return", calc_bus.calc_return, 32'd0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    chk("post_rst_busy", {31'd0, calc_bus.calc_busy}, 32'd0);

    // Request rising around cycle 100
    repeat (90) @(negedge clk);
    run_call("c1_1_c2_2", 32'd1, 32'd2, 32'hFFFF_FFFE);
    run_call("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5);
    run_call("c2_zero", 32'd7, 32'd0, 32'd9);

    // Randomized calls, varied multiplier widths; back-to-back spacing
    for (int k = 0; k < 10; k++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      c = $urandom;
      run_call("rand", a, b, c);
    end

    // Held request with arguments changed mid-call: exactly one call
    a = 32'h1234_5678; b = 32'h0000_0F0F; c = 32'h0BAD_F00D;
    calc_bus.calc_req = 1'b0;
    calc_bus.calc_c1 = a; calc_bus.calc_c2 = b; calc_bus.calc_c3 = c;
    @(negedge clk);
    calc_bus.calc_req = 1'b1;
    wait_call("held", model_result(a, b, c), model_len(b), 1'b1);
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (calc_bus.calc_busy !== 1'b0) busy_seen++;
    end
    chk("held_no_restart", busy_seen, 32'd0);
    chk("held_result_kept", calc_bus.calc_return, model_result(a, b, c));

    // Reset pulsed at busy cycle 10, request left high through release
    a = 32'hDEAD_BEEF; b = 32'h8000_0001; c = 32'd3;
    calc_bus.calc_req = 1'b0;
    calc_bus.calc_c1 = a; calc_bus.calc_c2 = b; calc_bus.calc_c3 = c;
    @(negedge clk);
    calc_bus.calc_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", {31'd0, calc_bus.calc_busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, calc_bus.calc_busy}, 32'd0);
    chk("abort_return", calc_bus.calc_return, 32'd0);
    exp_ret = 32'd0;
    @(negedge clk);
    a = 32'h0000_0101; b = 32'h0000_0033; c = 32'h0000_1000;
    calc_bus.calc_c1 = a; calc_bus.calc_c2 = b; calc_bus.calc_c3 = c;
    reset = 1'b1;
    // req still high at release: starts on the first edge
    wait_call("req_at_release", model_result(a, b, c), model_len(b), 1'b0);

    // Back-to-back after release
    run_call("after_abort", 32'h0000_00FF, 32'h0000_00FF, 32'd1);
    r = model_result(32'hCAFE_0001, 32'h0000_0002, 32'd0);
    run_call("b2b", 32'hCAFE_0001, 32'h0000_0002, 32'd0);
    chk("b2b_final", calc_bus.calc_return, r);

    calc_bus.calc_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
